// File: rtl/m10k_column_reader_if.sv
// PIO readback handshake plus the shared M10K read port, as seen by the column reader.
// master = reader side, slave = HPS/memory side.
interface m10k_column_reader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 18
);
    logic              pio_valid;
    logic [DATA_W-1:0] pio_q;
    logic [ADDR_W-1:0] pio_idx;
    logic              pio_ack;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_sel;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output pio_valid, pio_q, pio_idx, mem_rd_addr, mem_rd_sel,
        input  pio_ack, mem_q
    );

    modport slave (
        input  pio_valid, pio_q, pio_idx, mem_rd_addr, mem_rd_sel,
        output pio_ack, mem_q
    );
endinterface

// File: rtl/m10k_column_reader.sv
// Drains one M10K column to the HPS, one word per four-phase req/ack; first word valid 4 cycles after start edge.
// Stalls in PRESENT/RELEASE for the HPS; optional running checksum under READBACK_CHECKSUM_EN.
module m10k_column_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W:0]      pio_height,
    m10k_column_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    checksum
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_PRESENT, S_RELEASE, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, next_state;
    logic              start_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] pio_q_r;
    logic [ADDR_W-1:0] pio_idx_r;
    logic              accept;
    logic              advance;

    logic              start_rise;
    logic [ADDR_W:0]   height_clamped;
    logic              last_word;

    assign start_rise     = start & ~start_d;
    assign height_clamped = (pio_height > MAX_LEN) ? MAX_LEN : pio_height;
    // len is one bit wider than addr so a full column compares without wrap
    assign last_word      = ({1'b0, addr} == (len - ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        advance       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        bus.pio_valid = 1'b0;
        bus.mem_rd_sel = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start_rise) begin
                    accept     = 1'b1;
                    next_state = (height_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy           = 1'b1;
                bus.mem_rd_sel = 1'b1;
                next_state     = S_WAIT;
            end
            S_WAIT: begin
                busy           = 1'b1;
                bus.mem_rd_sel = 1'b1;
                next_state     = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy           = 1'b1;
                bus.mem_rd_sel = 1'b1;
                next_state     = S_PRESENT;
            end
            S_PRESENT: begin
                busy          = 1'b1;
                bus.pio_valid = 1'b1;
                if (bus.pio_ack) next_state = S_RELEASE;
            end
            S_RELEASE: begin
                busy = 1'b1;
                if (!bus.pio_ack) begin
                    if (last_word) begin
                        next_state = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = S_ISSUE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // start_d reloads from start during reset so a held-high start cannot retrigger
    always_ff @(posedge clk) begin
        if (reset) begin
            start_d   <= start;
            addr      <= '0;
            len       <= '0;
            pio_q_r   <= '0;
            pio_idx_r <= '0;
        end else begin
            start_d <= start;
            if (accept) begin
                len  <= height_clamped;
                addr <= '0;
            end else if (advance) begin
                addr <= addr + 1'b1;
            end
            if (state == S_CAPTURE) begin
                pio_q_r   <= bus.mem_q;
                pio_idx_r <= addr;
            end
        end
    end

    assign bus.mem_rd_addr = addr;
    assign bus.pio_q       = pio_q_r;
    assign bus.pio_idx     = pio_idx_r;

`ifdef READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_r <= '0;
        end else if (accept) begin
            checksum_r <= '0;
        end else if (state == S_CAPTURE) begin
            checksum_r <= checksum_r + bus.mem_q;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_m10k_column_reader.sv
// Directed bench for m10k_column_reader with a behavioural 1-cycle M10K and a scripted HPS acker.
module tb_m10k_column_reader;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 18;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   pio_height;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [512];

    m10k_column_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    m10k_column_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pio_height (pio_height),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_q <= mem[bus.mem_rd_addr];

    function automatic logic [DATA_W-1:0] exp_word(input int a);
        if (a < 32) return DATA_W'(a + 1);
        return 18'h3FFFF - DATA_W'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, bus.pio_valid, 0);
        chk({tag, "_q"}, bus.pio_q, 0);
        chk({tag, "_idx"}, bus.pio_idx, 0);
        chk({tag, "_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_sel"}, bus.mem_rd_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_csum"}, checksum, 0);
    endtask

    task automatic do_start(input int h);
        @(negedge clk);
        pio_height = (ADDR_W+1)'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // HPS model: acks each new word after ack_delay cycles; returns early when word stop_at is presented
    task automatic dump(input int first, input int ack_delay, input int stop_at,
                        output int words, output int errs, output int last);
        int wait_cnt;
        int guard;
        wait_cnt = -1;
        guard    = 0;
        words    = 0;
        errs     = 0;
        last     = -1;
        while (guard < 20000) begin
            if (bus.pio_valid && !bus.pio_ack) begin
                if (wait_cnt < 0) begin
                    if (int'(bus.pio_idx) != first + words) errs++;
                    if (bus.pio_q !== exp_word(first + words)) errs++;
                    last = int'(bus.pio_idx);
                    if (first + words == stop_at) return;
                    words++;
                    wait_cnt = 0;
                end
                if (wait_cnt >= ack_delay) bus.pio_ack = 1'b1;
                else wait_cnt++;
            end else if (bus.pio_ack && !bus.pio_valid) begin
                bus.pio_ack = 1'b0;
                wait_cnt = -1;
            end else if (done && !bus.pio_ack) begin
                break;
            end
            @(negedge clk);
            guard++;
        end
        chk("dump_in_time", guard < 20000, 1);
    endtask

    initial begin
        int w, e, l, n, vh;
        logic [DATA_W-1:0] full_sum;

        reset       = 1'b1;
        start       = 1'b0;
        pio_height  = '0;
        bus.pio_ack = 1'b0;
        full_sum    = '0;
        for (int a = 0; a < 512; a++) begin
            mem[a]   = exp_word(a);
            full_sum = full_sum + exp_word(a);
        end
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;

        // first dump: latency and in-order delivery
        do_start(32);
        chk("t1_sel", bus.mem_rd_sel, 1);
        chk("t1_busy", busy, 1);
        chk("t1_addr", bus.mem_rd_addr, 0);
        chk("t1_valid_early", bus.pio_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_valid_early", bus.pio_valid, 0);
        @(negedge clk);
        chk("t4_valid", bus.pio_valid, 1);
        chk("t4_idx", bus.pio_idx, 0);
        chk("t4_q", bus.pio_q, 1);
        dump(0, 5, -1, w, e, l);
        chk("d32_words", w, 32);
        chk("d32_errs", e, 0);
        chk("d32_last", l, 31);
        chk("d32_done", done, 1);
        chk("d32_busy", busy, 0);
`ifdef READBACK_CHECKSUM_EN
        chk("d32_csum", checksum, 528);
`else
        chk("d32_csum", checksum, 0);
`endif

        // restart after done, with a stray start edge mid-dump
        do_start(32);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dump(0, 1, -1, w, e, l);
        chk("rs_words", w, 32);
        chk("rs_errs", e, 0);
        chk("rs_done", done, 1);
`ifdef READBACK_CHECKSUM_EN
        chk("rs_csum", checksum, 528);
`else
        chk("rs_csum", checksum, 0);
`endif

        // zero height from IDLE
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("h0_pre_done", done, 0);
        do_start(0);
        chk("h0_done", done, 1);
        chk("h0_busy", busy, 0);
        vh = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.pio_valid || busy) vh++;
        end
        chk("h0_quiet", vh, 0);
        chk("h0_done_held", done, 1);

        // ack held high for 20 cycles
        do_start(4);
        n = 0;
        while (!bus.pio_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_valid", bus.pio_valid, 1);
        bus.pio_ack = 1'b1;
        vh = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.pio_valid) vh++;
        end
        chk("hold_valid_low", vh, 0);
        chk("hold_idx", bus.pio_idx, 0);
        chk("hold_addr", bus.mem_rd_addr, 0);
        chk("hold_busy", busy, 1);
        chk("hold_sel", bus.mem_rd_sel, 0);
        bus.pio_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pio_valid && n < 20);
        chk("hold_next_lat", n, 4);
        chk("hold_next_idx", bus.pio_idx, 1);
        chk("hold_next_q", bus.pio_q, 2);
        dump(1, 2, -1, w, e, l);
        chk("hold_words", w, 3);
        chk("hold_errs", e, 0);
        chk("hold_last", l, 3);

        // reset while word 7 is being presented, start held high through it
        do_start(32);
        dump(0, 1, 7, w, e, l);
        chk("mid_last", l, 7);
        chk("mid_errs", e, 0);
        chk("mid_valid", bus.pio_valid, 1);
        reset = 1'b1;
        start = 1'b1;
        bus.pio_ack = 1'b0;
        @(negedge clk);
        chk_quiet("midrst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_retrig", busy, 0);
        start = 1'b0;
        do_start(10);
        dump(0, 0, -1, w, e, l);
        chk("fresh_words", w, 10);
        chk("fresh_errs", e, 0);
        chk("fresh_last", l, 9);
`ifdef READBACK_CHECKSUM_EN
        chk("fresh_csum", checksum, 55);
`endif

        // oversize height clamps to the full column
        do_start(600);
        dump(0, 0, -1, w, e, l);
        chk("full_words", w, 512);
        chk("full_errs", e, 0);
        chk("full_last", l, 511);
        chk("full_done", done, 1);
`ifdef READBACK_CHECKSUM_EN
        chk("full_csum", checksum, full_sum);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
